// File: rtl/vga_pkg.sv
// Shared definitions for the VGA board renderer.
//   - Default 640x480@60 timing constants (H_TOTAL, V_TOTAL, sync bounds).
//   - RGB444 colour constants.
//   - Cell-owner encoding (2 bits per cell in board_state).
//   - Per-axis incremental region tracker (type plus step/start helpers).
//     Each screen axis is tracked as: before the board, inside a cell,
//     inside a gap, or past the board.
package vga_pkg;

  // Default VGA 640x480@60 timing, in pixel ticks / lines.
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
  localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

  // Width of the scan counters and intra-cell offset counters.
  localparam int XW = 12;
  localparam logic [XW-1:0] AX_ONE = {{(XW-1){1'b0}}, 1'b1};

  // RGB444 colours, {R,G,B}.
  localparam logic [11:0] COL_P1     = 12'hF00;
  localparam logic [11:0] COL_P2     = 12'h0F0;
  localparam logic [11:0] COL_RSVD   = 12'hF0F;
  localparam logic [11:0] COL_GRID   = 12'hFFF;
  localparam logic [11:0] COL_CURSOR = 12'hFF0;
  localparam logic [11:0] COL_EMPTY  = 12'h222;
  localparam logic [11:0] COL_BG     = 12'h000;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10,
    RSVD  = 2'b11
  } owner_e;

  typedef enum logic [1:0] {
    AX_BEFORE,
    AX_CELL,
    AX_GAP,
    AX_AFTER
  } axis_phase_e;

  // off counts pixels within the current phase (before/cell/gap);
  // idx is the cell column (x axis) or row (y axis).
  typedef struct packed {
    axis_phase_e     phase;
    logic [XW-1:0]   off;
    logic [7:0]      idx;
  } axis_t;

  // Tracker state for screen coordinate 0.
  function automatic axis_t axis_start(input logic [XW-1:0] origin);
    axis_t a;
    a.off   = '0;
    a.idx   = '0;
    a.phase = (origin == '0) ? AX_CELL : AX_BEFORE;
    return a;
  endfunction

  // Tracker state for coordinate+1 given the state at coordinate.
  // gap_len must be at least 1.
  function automatic axis_t axis_step(input axis_t         a,
                                      input logic [XW-1:0] origin,
                                      input logic [XW-1:0] cell_len,
                                      input logic [XW-1:0] gap_len,
                                      input logic [7:0]    n);
    axis_t nx;
    nx = a;
    case (a.phase)
      AX_BEFORE: begin
        if (a.off == origin - AX_ONE) begin
          nx.phase = AX_CELL;
          nx.off   = '0;
        end else begin
          nx.off = a.off + AX_ONE;
        end
      end
      AX_CELL: begin
        if (a.off == cell_len - AX_ONE) begin
          nx.off   = '0;
          nx.phase = (a.idx == n - 8'd1) ? AX_AFTER : AX_GAP;
        end else begin
          nx.off = a.off + AX_ONE;
        end
      end
      AX_GAP: begin
        if (a.off == gap_len - AX_ONE) begin
          nx.phase = AX_CELL;
          nx.off   = '0;
          nx.idx   = a.idx + 8'd1;
        end else begin
          nx.off = a.off + AX_ONE;
        end
      end
      default: nx = a;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-tick divider, h/v scan counters, raw
// (undelayed) active-low syncs, active-area flag and frame_start pulse.
// Ports:
//   clk, reset        system clock, async active-high reset
//   tick              one-clk pulse every CLK_DIV clocks; every stage
//                     downstream advances only when tick is high
//   h_cnt, v_cnt      current scan position (counter stage)
//   line_end          h_cnt is the last pixel of the line
//   frame_end         line_end on the last line of the frame
//   hsync_raw, vsync_raw  syncs for the current counter value
//   active            current counter value is inside the visible area
//   frame_start       registered one-clk pulse after the tick that
//                     consumes scan position (0,0)
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic          clk,
  input  logic          reset,
  output logic          tick,
  output logic [XW-1:0] h_cnt,
  output logic [XW-1:0] v_cnt,
  output logic          line_end,
  output logic          frame_end,
  output logic          hsync_raw,
  output logic          vsync_raw,
  output logic          active,
  output logic          frame_start
);

  localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HSS = H_ACTIVE + H_FP;
  localparam int HSE = HSS + H_SYNC;
  localparam int VSS = V_ACTIVE + V_FP;
  localparam int VSE = VSS + V_SYNC;

  logic [7:0] div_cnt;

  assign tick = (div_cnt == 8'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  assign line_end  = (h_cnt == XW'(HT - 1));
  assign frame_end = line_end && (v_cnt == XW'(VT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (line_end) begin
        h_cnt <= '0;
        v_cnt <= frame_end ? '0 : v_cnt + AX_ONE;
      end else begin
        h_cnt <= h_cnt + AX_ONE;
      end
    end
  end

  assign hsync_raw = !((h_cnt >= XW'(HSS)) && (h_cnt < XW'(HSE)));
  assign vsync_raw = !((v_cnt >= XW'(VSS)) && (v_cnt < XW'(VSE)));
  assign active    = (h_cnt < XW'(H_ACTIVE)) && (v_cnt < XW'(V_ACTIVE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: rtl/vga_board_renderer.sv
// NxN game-board renderer for VGA (default 640x480@60, RGB444).
// Draws grid lines, cell owners, a cursor outline and a win-line
// highlight from a board snapshot taken at the start of vertical blank,
// so input changes during a frame never tear the picture.
// Pipeline, advancing only on the pixel tick:
//   S0 scan counters -> S1 region/cell decode -> S2 colour and sync regs.
//   Pins show counter position (h,v) two ticks after it is presented.
// Ports:
//   clk, reset            system clock, async active-high reset
//   board_state [2*NC]    2 bits per cell, row-major (00 empty, 01 P1,
//                         10 P2, 11 reserved)
//   cursor_idx, cursor_en cursor cell and enable (idx >= NC: no cursor)
//   win_mask [NC]         cells on the winning line
//   hsync, vsync          active-low syncs, aligned with colour
//   VGA_R/VGA_G/VGA_B     colour
//   frame_start           one-clk pulse when scan position (0,0) is ticked
// Optional build macro VGA_BOARD_BLINK_EN: a 6-bit frame counter makes win
// cells blink (interior black while bit 5 is set). Without it, win cells
// are highlighted steadily.
module vga_board_renderer
  import vga_pkg::*;
#(
  parameter int BOARD_N  = 3,
  parameter int CELL_W   = 100,
  parameter int CELL_H   = 100,
  parameter int GAP      = 8,
  parameter int ORIGIN_X = 55,
  parameter int ORIGIN_Y = 28,
  parameter int CURSOR_T = 4,
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  localparam int NC      = BOARD_N * BOARD_N,
  localparam int CIDX_W  = (NC > 1) ? $clog2(NC) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2*NC-1:0]   board_state,
  input  logic [CIDX_W-1:0] cursor_idx,
  input  logic              cursor_en,
  input  logic [NC-1:0]     win_mask,
  output logic              hsync,
  output logic              vsync,
  output logic [3:0]        VGA_R,
  output logic [3:0]        VGA_G,
  output logic [3:0]        VGA_B,
  output logic              frame_start
);

  // ---------------------------------------------------------------- S0
  logic          tick;
  logic [XW-1:0] h_cnt, v_cnt;
  logic          line_end, frame_end;
  logic          hsync_raw, vsync_raw, active;

  vga_timing_gen #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .line_end    (line_end),
    .frame_end   (frame_end),
    .hsync_raw   (hsync_raw),
    .vsync_raw   (vsync_raw),
    .active      (active),
    .frame_start (frame_start)
  );

  // ---------------------------------------------------------- snapshot
  logic [2*NC-1:0]   snap_board;
  logic [NC-1:0]     snap_win;
  logic [CIDX_W-1:0] snap_cur_idx;
  logic              snap_cur_on;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_board   <= '0;
      snap_win     <= '0;
      snap_cur_idx <= '0;
      snap_cur_on  <= 1'b0;
    end else if (tick && (v_cnt == XW'(V_ACTIVE)) && (h_cnt == '0)) begin
      snap_board   <= board_state;
      snap_win     <= win_mask;
      snap_cur_idx <= cursor_idx;
      // An out-of-range index is folded into "cursor off" here so the
      // decode only needs an equality compare.
      snap_cur_on  <= cursor_en && (int'(cursor_idx) < NC);
    end
  end

  // ------------------------------------------------- incremental decode
  // ax_q/ay_q describe the current h_cnt/v_cnt position; they are stepped
  // on the same ticks as the counters. row_base_q = row * BOARD_N, kept
  // by repeated addition so the cell index needs no multiplier.
  axis_t             ax_q, ay_q;
  logic [CIDX_W-1:0] row_base_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ax_q       <= axis_start(XW'(ORIGIN_X));
      ay_q       <= axis_start(XW'(ORIGIN_Y));
      row_base_q <= '0;
    end else if (tick) begin
      if (line_end) begin
        ax_q <= axis_start(XW'(ORIGIN_X));
        if (frame_end) begin
          ay_q       <= axis_start(XW'(ORIGIN_Y));
          row_base_q <= '0;
        end else begin
          ay_q <= axis_step(ay_q, XW'(ORIGIN_Y), XW'(CELL_H), XW'(GAP), 8'(BOARD_N));
          if ((ay_q.phase == AX_GAP) && (ay_q.off == XW'(GAP - 1))) begin
            row_base_q <= row_base_q + CIDX_W'(BOARD_N);
          end
        end
      end else begin
        ax_q <= axis_step(ax_q, XW'(ORIGIN_X), XW'(CELL_W), XW'(GAP), 8'(BOARD_N));
      end
    end
  end

  logic              x_cell, y_cell, x_box, y_box;
  logic              in_cell, in_grid, on_edge, on_cursor;
  logic [CIDX_W-1:0] cell_idx;
  owner_e            cell_owner;
  logic              cell_win;

  assign x_cell   = (ax_q.phase == AX_CELL);
  assign y_cell   = (ay_q.phase == AX_CELL);
  assign x_box    = x_cell || (ax_q.phase == AX_GAP);
  assign y_box    = y_cell || (ay_q.phase == AX_GAP);
  assign in_cell  = x_cell && y_cell;
  assign in_grid  = x_box && y_box && !in_cell;
  assign cell_idx = row_base_q + CIDX_W'(ax_q.idx);

  assign on_edge  = (ax_q.off < XW'(CURSOR_T)) || (ax_q.off >= XW'(CELL_W - CURSOR_T)) ||
                    (ay_q.off < XW'(CURSOR_T)) || (ay_q.off >= XW'(CELL_H - CURSOR_T));
  assign on_cursor = in_cell && snap_cur_on && (cell_idx == snap_cur_idx) && on_edge;

  // Cell lookup as a constant-indexed mux over the snapshot.
  always_comb begin
    cell_owner = EMPTY;
    cell_win   = 1'b0;
    for (int k = 0; k < NC; k++) begin
      if (cell_idx == CIDX_W'(k)) begin
        cell_owner = owner_e'(snap_board[2*k +: 2]);
        cell_win   = snap_win[k];
      end
    end
  end

  // ---------------------------------------------------------------- S1
  logic   s1_active, s1_cursor, s1_grid, s1_cell, s1_win;
  owner_e s1_owner;
  logic   s1_hsync, s1_vsync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_active <= 1'b0;
      s1_cursor <= 1'b0;
      s1_grid   <= 1'b0;
      s1_cell   <= 1'b0;
      s1_win    <= 1'b0;
      s1_owner  <= EMPTY;
      s1_hsync  <= 1'b1;
      s1_vsync  <= 1'b1;
    end else if (tick) begin
      s1_active <= active;
      s1_cursor <= on_cursor;
      s1_grid   <= in_grid;
      s1_cell   <= in_cell;
      s1_win    <= cell_win;
      s1_owner  <= cell_owner;
      s1_hsync  <= hsync_raw;
      s1_vsync  <= vsync_raw;
    end
  end

  // ------------------------------------------------------------- blink
  logic blink_off;

`ifdef VGA_BOARD_BLINK_EN
  logic [5:0] frame_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 6'd1;
    end
  end

  assign blink_off = frame_cnt[5];
`else
  assign blink_off = 1'b0;
`endif

  // ---------------------------------------------------------------- S2
  logic [11:0] cell_col, pix_col, rgb_q;

  always_comb begin
    case (s1_owner)
      P1:      cell_col = COL_P1;
      P2:      cell_col = COL_P2;
      RSVD:    cell_col = COL_RSVD;
      default: cell_col = COL_EMPTY;
    endcase
    // Win highlight forces blue full-on for owned cells only.
    if (s1_win && (s1_owner != EMPTY)) begin
      cell_col[3:0] = 4'hF;
    end
    if (s1_win && blink_off) begin
      cell_col = COL_BG;
    end

    if (!s1_active) begin
      pix_col = COL_BG;
    end else if (s1_cursor) begin
      pix_col = COL_CURSOR;
    end else if (s1_grid) begin
      pix_col = COL_GRID;
    end else if (s1_cell) begin
      pix_col = cell_col;
    end else begin
      pix_col = COL_BG;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (tick) begin
      rgb_q <= pix_col;
      hsync <= s1_hsync;
      vsync <= s1_vsync;
    end
  end

  assign VGA_R = rgb_q[11:8];
  assign VGA_G = rgb_q[7:4];
  assign VGA_B = rgb_q[3:0];

endmodule

// File: tb/tb_vga_board_renderer.sv
// Testbench for vga_board_renderer using a reduced screen geometry so that
// many whole frames fit in a short run. A producer process computes the
// expected {hsync,vsync,RGB} of every scanned pixel from the geometric
// rules (division/modulo on screen coordinates) and pushes it into exp_q;
// a monitor pops one entry per pixel tick and compares with the pins.
module tb_vga_board_renderer;

  localparam int BOARD_N  = 3;
  localparam int CELL_W   = 7;
  localparam int CELL_H   = 5;
  localparam int GAP      = 2;
  localparam int ORIGIN_X = 4;
  localparam int ORIGIN_Y = 3;
  localparam int CURSOR_T = 2;
  localparam int CLK_DIV  = 2;
  localparam int H_ACTIVE = 40;
  localparam int H_FP     = 3;
  localparam int H_SYNC   = 5;
  localparam int H_BP     = 4;
  localparam int V_ACTIVE = 24;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 3;

  localparam int NC         = BOARD_N * BOARD_N;
  localparam int CIDX_W     = $clog2(NC);
  localparam int HT         = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT         = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME      = HT * VT;
  localparam int FRAME_CLKS = FRAME * CLK_DIV;
  localparam int BW         = BOARD_N * CELL_W + (BOARD_N - 1) * GAP;
  localparam int BH         = BOARD_N * CELL_H + (BOARD_N - 1) * GAP;
  localparam logic [13:0] RESET_WORD = {1'b1, 1'b1, 12'h000};

  // ------------------------------------------------- clock and reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [2*NC-1:0]   board_state;
  logic [CIDX_W-1:0] cursor_idx;
  logic              cursor_en;
  logic [NC-1:0]     win_mask;
  logic              hsync, vsync, frame_start;
  logic [3:0]        VGA_R, VGA_G, VGA_B;

  vga_board_renderer #(
    .BOARD_N(BOARD_N), .CELL_W(CELL_W), .CELL_H(CELL_H), .GAP(GAP),
    .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y), .CURSOR_T(CURSOR_T),
    .CLK_DIV(CLK_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .board_state (board_state),
    .cursor_idx  (cursor_idx),
    .cursor_en   (cursor_en),
    .win_mask    (win_mask),
    .hsync       (hsync),
    .vsync       (vsync),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .frame_start (frame_start)
  );

  // ------------------------------------------------------- scoreboard
  logic [13:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model of the displayed board (what was latched at vertical blank).
  logic [2*NC-1:0]   m_board;
  logic [NC-1:0]     m_win;
  logic [CIDX_W-1:0] m_cidx;
  logic              m_cen;

  function automatic logic [13:0] model_pixel(input int h, input int v);
    logic        hs, vs;
    logic [11:0] col;
    logic [1:0]  own;
    int bx, by, c, r, ox, oy, k;
    hs  = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
    vs  = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
    col = 12'h000;
    if (h < H_ACTIVE && v < V_ACTIVE) begin
      bx = h - ORIGIN_X;
      by = v - ORIGIN_Y;
      if (bx >= 0 && bx < BW && by >= 0 && by < BH) begin
        c  = bx / (CELL_W + GAP);
        ox = bx % (CELL_W + GAP);
        r  = by / (CELL_H + GAP);
        oy = by % (CELL_H + GAP);
        if (ox < CELL_W && oy < CELL_H) begin
          k = r * BOARD_N + c;
          if (m_cen && int'(m_cidx) < NC && k == int'(m_cidx) &&
              (ox < CURSOR_T || ox >= CELL_W - CURSOR_T ||
               oy < CURSOR_T || oy >= CELL_H - CURSOR_T)) begin
            col = 12'hFF0;
          end else begin
            own = m_board[2*k +: 2];
            case (own)
              2'b01:   col = 12'hF00;
              2'b10:   col = 12'h0F0;
              2'b11:   col = 12'hF0F;
              default: col = 12'h222;
            endcase
            if (m_win[k] && own != 2'b00) col[3:0] = 4'hF;
          end
        end else begin
          col = 12'hFFF;
        end
      end
    end
    return {hs, vs, col};
  endfunction

  // Producer: knows the tick schedule (every CLK_DIV clocks after reset
  // release) and the raster order, so it pushes the expected pins value
  // for each pixel as the DUT consumes it.
  int clk_cnt, tick_cnt, p, ph, pv;
  bit tick_flag, fs_exp;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_cnt   = 0;
      tick_cnt  = 0;
      tick_flag = 0;
      fs_exp    = 0;
      m_board   = '0;
      m_win     = '0;
      m_cidx    = '0;
      m_cen     = 1'b0;
      exp_q.delete();
      exp_q.push_back(RESET_WORD);
    end else begin
      clk_cnt++;
      tick_flag = 0;
      fs_exp    = 0;
      if (clk_cnt % CLK_DIV == 0) begin
        p  = tick_cnt % FRAME;
        ph = p % HT;
        pv = p / HT;
        exp_q.push_back(model_pixel(ph, pv));
        if (ph == 0 && pv == V_ACTIVE) begin
          m_board = board_state;
          m_win   = win_mask;
          m_cidx  = cursor_idx;
          m_cen   = cursor_en;
        end
        fs_exp    = (p == 0);
        tick_cnt++;
        tick_flag = 1;
      end
    end
  end

  // Monitor: one comparison per tick for the pins, one per clock for
  // frame_start.
  logic [13:0] got_w, exp_w;
  always @(negedge clk) begin
    if (!reset) begin
      check("frame_start", {31'd0, frame_start}, {31'd0, fs_exp});
      if (tick_flag) begin
        if (exp_q.size() == 0) begin
          check("queue_underflow", 32'd0, 32'd1);
        end else begin
          exp_w = exp_q.pop_front();
          got_w = {hsync, vsync, VGA_R, VGA_G, VGA_B};
          check("pixel", {18'd0, got_w}, {18'd0, exp_w});
        end
      end
    end
  end

  // -------------------------------------------------------- driver
  task automatic set_random();
    board_state = (2*NC)'($urandom);
    win_mask    = NC'($urandom);
    cursor_idx  = CIDX_W'($urandom_range(0, (1 << CIDX_W) - 1));
    cursor_en   = 1'($urandom);
  endtask

  task automatic set_scenario(input int f);
    case (f)
      0: begin
        board_state = (2*NC)'(2'b01); win_mask = '0; cursor_en = 1'b0; cursor_idx = '0;
      end
      1: begin
        board_state = (2*NC)'(2'b01); win_mask = '0; cursor_en = 1'b1; cursor_idx = CIDX_W'(4);
      end
      2: begin
        board_state = (2*NC)'($urandom); win_mask = '0; cursor_en = 1'b1; cursor_idx = CIDX_W'(9);
      end
      3: begin
        board_state = (2*NC)'($urandom);
        board_state[1:0]   = 2'b10;
        board_state[9:8]   = 2'b10;
        board_state[17:16] = 2'b10;
        win_mask = 9'b100010001; cursor_en = 1'b0; cursor_idx = '0;
      end
      4: begin
        board_state = '1; win_mask = '1; cursor_en = 1'b1; cursor_idx = CIDX_W'(NC - 1);
      end
      default: set_random();
    endcase
  endtask

  task automatic check_reset_pins(input string name);
    check({name, "_rgb"}, {20'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
    check({name, "_hsync"}, {31'd0, hsync}, 32'd1);
    check({name, "_vsync"}, {31'd0, vsync}, 32'd1);
    check({name, "_frame_start"}, {31'd0, frame_start}, 32'd0);
  endtask

  task automatic run_frames(input int first, input int count);
    int w;
    for (int f = first; f < first + count; f++) begin
      set_random();
      w = $urandom_range(10, FRAME_CLKS / 4);
      repeat (w) @(negedge clk);
      set_random();
      repeat (FRAME_CLKS / 2 - w) @(negedge clk);
      // Mid-frame (inside the active area): becomes visible next frame.
      set_scenario(f);
      repeat (FRAME_CLKS - FRAME_CLKS / 2) @(negedge clk);
    end
  endtask

  initial begin
    set_random();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_pins("reset");
    reset = 1'b0;

    run_frames(0, 9);

    // Asynchronous reset in the middle of a frame.
    repeat ($urandom_range(100, FRAME_CLKS - 100)) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_pins("midreset");
    repeat (3) @(negedge clk);
    check_reset_pins("midreset_hold");
    reset = 1'b0;

    run_frames(5, 3);

    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
